uart_const_baud_rx: RTL and testbench

Fixed-baud UART receiver, 8N1, LSB first. It is the consumer of the serial line driven by the constant-baud transmitter. It recovers each byte by oversampling at the system clock and sampling at bit centres. It presents the byte with a one-cycle valid strobe and flags framing errors. It serves as the loopback/readback stage for the baud-detect bench and for FPGA control-word reception.

---
 rtl/uart_defs.sv | 27 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_const_baud_rx.sv | 127 ++++++++++++
 tb/tb_uart_const_baud_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions used by the constant-baud receiver and transmitter.
//   rx_state_t       : receiver frame state encoding (3 bits)
//   DATA_BITS        : payload bits per frame (8N1)
//   calc_baud_limit  : clock cycles per bit, clock_freq / baud_rate
//   calc_half        : bit-centre offset, baud_limit / 2
package uart_defs;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned calc_baud_limit(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_half(input int unsigned baud_limit);
    return baud_limit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver.
//   clk  : system clock
//   rst  : asynchronous active-low reset (all flops reset to 1 = idle line)
//   rx   : asynchronous serial input
//   rx_s : rx after a 2-FF synchroniser
//   fall : one-cycle strobe on a high-to-low transition of rx_s
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_const_baud_rx.sv
// Fixed-baud UART receiver, 8N1, LSB first, majority-voted bit-centre sampling.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   rx           : serial line, idle high
//   rx_data      : last correctly framed byte, held until the next good frame
//   rx_valid     : one-cycle pulse, rx_data updated
//   rx_frame_err : one-cycle pulse, stop bit sampled low
//   rx_busy      : high while a frame is in progress
module uart_const_baud_rx
  import uart_defs::*;
#(
  parameter int unsigned clock_freq = 100_000_000,
  parameter int unsigned baud_rate  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned BAUD_LIMIT = calc_baud_limit(clock_freq, baud_rate);
  localparam int unsigned HALF       = calc_half(BAUD_LIMIT);
  localparam int unsigned CNT_W      = $clog2(BAUD_LIMIT + 1);

  generate
    if (BAUD_LIMIT < 8) begin : g_baud_check
      $error("uart_const_baud_rx: clock_freq / baud_rate must be at least 8");
    end
  endgenerate

  logic                 rx_s;
  logic                 fall;
  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 vote_a, vote_b;
  logic                 voted;
  logic                 sample;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  // Three-sample majority: two earlier samples held, third taken live.
  assign voted  = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
  assign sample = (state == START || state == DATA || state == STOP) &&
                  (baud_cnt == CNT_W'(HALF + 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fall) state_next = START;
      START:   if (sample) state_next = voted ? IDLE : DATA;
      DATA:    if (sample && bit_idx == 3'd7) state_next = STOP;
      STOP:    if (sample) state_next = voted ? IDLE : BRK;
      BRK:     if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The bit timer is zeroed in IDLE/BRK and on start detection; across
  // START->DATA->STOP it keeps its phase so every later sample point lands
  // exactly one bit period after the previous one (no cumulative drift).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
    end else if (state == IDLE || state_next == IDLE || state_next == BRK) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_W'(BAUD_LIMIT - 1)) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else begin
      if (baud_cnt == CNT_W'(HALF - 1)) vote_a <= rx_s;
      if (baud_cnt == CNT_W'(HALF))     vote_b <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (sample) begin
      if (state == START) begin
        bit_idx <= '0;
      end else if (state == DATA) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {voted, shreg[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid     <= (state == STOP) && sample && voted;
      rx_frame_err <= (state == STOP) && sample && !voted;
      rx_busy      <= (state_next != IDLE);
      if ((state == STOP) && sample && voted) rx_data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_const_baud_rx.sv
module tb_uart_const_baud_rx;

  localparam int unsigned BIT_CYC = 10;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_valid_cyc = 0;
  int         busy_run = 0;
  int         max_busy_run = 0;
  int         pulse_cnt = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] last_good = 8'h00;

  uart_const_baud_rx #(
    .clock_freq (1_000_000),
    .baud_rate  (100_000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rx_busy) busy_run++;
    else busy_run = 0;
    if (busy_run > max_busy_run) max_busy_run = busy_run;
    if (rx_valid || rx_frame_err) begin
      pulse_cnt++;
      check("pulse_exclusive", {31'd0, rx_valid & rx_frame_err}, 32'd0);
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'd0, rx_valid}, {31'd0, rx_frame_err});
        check("unexpected_pulse_cnt", 32'd1, 32'd0 + exp_q.size());
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, rx_frame_err}, {31'd0, e.is_err});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
      end
      if (rx_valid) last_valid_cyc = cyc;
    end
    prev_pulse = rx_valid | rx_frame_err;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = d;
    last_good = d;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   t_start;
    int   lat;
    int   pulses_before;

    // Reset state
    rx = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data",  {24'd0, rx_data}, 32'h00);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_ferr",  {31'd0, rx_frame_err}, 32'd0);
    check("reset_busy",  {31'd0, rx_busy}, 32'd0);
    rst = 1'b1;
    idle(20);

    // 0xA5 with latency measurement
    t_start = cyc;
    send_byte(8'hA5);
    idle(10);
    drain("drain_a5");
    lat = last_valid_cyc - t_start;
    check("latency_a5", {31'd0, (lat >= 99 && lat <= 101)}, 32'd1);
    check("busy_after_a5", {31'd0, rx_busy}, 32'd0);

    // Back-to-back 0x00, 0xFF with a one-bit stop
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(10);
    drain("drain_b2b");
    check("data_after_b2b", {24'd0, rx_data}, 32'hFF);

    // 3-cycle low glitch on idle line
    pulses_before = pulse_cnt;
    max_busy_run = 0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("glitch_no_pulse", pulse_cnt - pulses_before, 32'd0);
    check("glitch_busy_short", {31'd0, (max_busy_run > 0 && max_busy_run < 12)}, 32'd1);

    // 0x3C with low stop bit, line held low 40 cycles
    e.is_err = 1'b1;
    e.data   = last_good;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i));
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("brk_busy_held", {31'd0, rx_busy}, 32'd1);
    check("brk_ferr_seen", exp_q.size(), 32'd0);
    idle(6);
    check("brk_busy_released", {31'd0, rx_busy}, 32'd0);
    check("brk_data_kept", {24'd0, rx_data}, 32'hFF);
    idle(10);

    // 0x0F with a 1-cycle low spike in the middle of data bit 3
    e.is_err  = 1'b0;
    e.data    = 8'h0F;
    last_good = 8'h0F;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'(8'h0F >> i));
    rx = 1'b1;
    repeat (6) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 4; i < 8; i++) send_bit(1'(8'h0F >> i));
    send_bit(1'b1);
    idle(10);
    drain("drain_spike");

    // Reset during data bit 4 of 0x55, then 0xC3
    pulses_before = pulse_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h55 >> i));
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    check("midrst_data",  {24'd0, rx_data}, 32'h00);
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_ferr",  {31'd0, rx_frame_err}, 32'd0);
    check("midrst_busy",  {31'd0, rx_busy}, 32'd0);
    rst = 1'b1;
    idle(40);
    check("midrst_no_pulse", pulse_cnt - pulses_before, 32'd0);
    send_byte(8'hC3);
    idle(10);
    drain("drain_c3");
    check("final_data", {24'd0, rx_data}, 32'hC3);
    check("final_busy", {31'd0, rx_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
